// File: rtl/polyeta_pack.sv
// polyeta_pack: packs one short-coefficient polynomial into the Dilithium secret-key byte form.
// Define POLYETA_PACK_RANGE_CHECK_EN to add the sticky out-of-range flag on port err.
module polyeta_pack #(
   parameter int N   = 256,
   parameter int ETA = 2,
   localparam int BITS = (ETA == 4) ? 4 : 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                rtr,
   input  logic [32*N-1:0]     linear_a,
   output logic [BITS*N-1:0]   linear_r,
`ifdef POLYETA_PACK_RANGE_CHECK_EN
   output logic                err,
`endif
   output logic                rts
);

   localparam int GROUPS = N / 8;
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

   state_t             state;
   logic [GW-1:0]      grp;
   logic [32*N-1:0]    coef_buf;
   logic [8*BITS-1:0]  grp_fields;

`ifdef POLYETA_PACK_RANGE_CHECK_EN
   logic [7:0]         oor;
   logic               any_oor;
   logic               err_acc;

   assign any_oor = |oor;
`endif

   // One lane per coefficient of the current group of eight.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : gen_lane
         logic signed [31:0] a;
         assign a = coef_buf[32*(8*int'(grp) + gi) +: 32];
         assign grp_fields[gi*BITS +: BITS] = BITS'(32'(ETA) - a);
`ifdef POLYETA_PACK_RANGE_CHECK_EN
         assign oor[gi] = (a < -ETA) || (a > ETA);
`endif
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         grp      <= '0;
         coef_buf <= '0;
         linear_r <= '0;
         rts      <= 1'b0;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
         err      <= 1'b0;
         err_acc  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               rts <= 1'b0;
               if (rtr) begin
                  coef_buf <= linear_a;
                  grp      <= '0;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
                  err      <= 1'b0;
                  err_acc  <= 1'b0;
`endif
                  state    <= PACK;
               end
            end
            PACK: begin
               for (int j = 0; j < 8; j++) begin
                  linear_r[BITS*(8*int'(grp) + j) +: BITS] <= grp_fields[BITS*j +: BITS];
               end
`ifdef POLYETA_PACK_RANGE_CHECK_EN
               err_acc <= err_acc | any_oor;
`endif
               grp <= grp + GW'(1);
               if (grp == GW'(GROUPS - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // The first DONE cycle always raises rts, guaranteeing a one-cycle minimum pulse.
               if (rts && !rtr) begin
                  rts   <= 1'b0;
                  state <= IDLE;
               end else begin
                  rts <= 1'b1;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
                  err <= err_acc;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
